sdram2_port_arb: RTL and testbench
==================================

// Module: sdram2_port_arb
// PURPOSE
//  Shares one sdram2 port (A or B) among NCLI requesters (CPU, DMA, loader). Tracks sdram2's
//  16-cycle slot frame from the shared sync input, grants round-robin, presents one request per
//  frame on the port inputs, and returns read data and ack at a fixed frame position.
//  Sits between client buses and sdram2; one instance per sdram2 port.
// PARAMETERS
//  NCLI    3   number of requesters (2..4)
//  RD_CNT  10  frame count, in the frame after issue, at which dout_a0 is stable and ack fires
// PORTS
//  clk          in   1         SDRAM clock, same clock as sdram2
//  rst_n        in   1         asynchronous reset, active low
//  sync         in   1         sdram2 sync; frame aligns on its falling edge
//  cli_req      in   NCLI      per-client request, level, held until ack
//  cli_we       in   NCLI      1 = write, 0 = read
//  cli_be       in   2*NCLI    write byte enables [1]=upper, [0]=lower
//  cli_addr     in   20*NCLI   word address [20:1] per client
//  cli_din      in   16*NCLI   write data per client
//  cli_ack      out  NCLI      one-cycle completion pulse per client
//  cli_dout     out  32        read longword, shared by all clients, valid with cli_ack
//  busy         out  1         a request is granted and not yet acked
//  port_addr0   out  20        -> sdram2 addr_x0
//  port_addr1   out  20        -> sdram2 addr_x1 (= port_addr0)
//  port_din     out  16        -> sdram2 din_x
//  port_wr      out  2         -> sdram2 wr_x
//  port_rd      out  1         -> sdram2 rd_x
//  port_dout0   in   32        <- sdram2 dout_x0
// BEHAVIOUR
//  Reset: all outputs 0, frame counter fc=0, FSM IDLE, round-robin pointer rr=0.
//  Frame counter fc[3:0]: increments each clk, wraps 15->0. Registered sync_old; on
//   sync_old & ~sync, fc <= 7 (same alignment rule as sdram2). sdram2 samples port at fc==15.
//  FSM:
//   IDLE  : at fc==14 and any cli_req: pick first requesting client at or after rr (wrap
//           modulo NCLI), latch index g; drive port_addr0/1, port_din, port_wr=cli_be&{2{we}},
//           port_rd=~we; busy<=1; -> ISSUE. Requests arriving at any other fc wait.
//   ISSUE : hold port outputs. At fc==0 (port sampled at 15): clear port_wr/port_rd to 0,
//           addresses/data keep last value; -> WAIT.
//   WAIT  : at fc==RD_CNT: cli_dout <= port_dout0 (reads; writes leave it unchanged),
//           cli_ack[g] <= 1 for one cycle, busy<=0, rr <= g+1 mod NCLI; -> IDLE.
//  Latency: grant at fc 14, command executes in next frame, ack at its fc RD_CNT; 12..27 clk
//   from req depending on phase. Max one access per frame per port.
//  Write with cli_be==0: issued as refresh-slot (port_wr=0, port_rd=0), still acked normally.
//  Client drops cli_req before ack: access still completes, ack still pulses (ignored).
//  Client keeps cli_req high after ack: treated as a new request at the next fc==14 only if
//   rr scan reaches it; ack cycle itself never grants.
//  Sync realignment in ISSUE (fc jumps to 7, skipping 15): outputs held, sample happens at next
//   fc==15, transition at following fc==0. Realignment in WAIT: ack waits for next fc==RD_CNT.
//  rst_n low mid-operation: immediate return to reset state; no ack generated for the
//   in-flight access; port_rd/port_wr forced 0 asynchronously.
//  Indices: g and rr are clog2(NCLI) bits; modulo wrap explicit for non-power-of-2 NCLI.
// TESTING
//  Single read, client1, addr 0x12345 -> port_rd=1, port_addr0=0x12345 over fc 14..15, cleared at
//   fc 0, ack[1] at next fc 10, cli_dout=port_dout0 model value.
//  Write client0 be=2'b01 din 0xA55A -> port_wr=2'b01, port_din=0xA55A sampled at fc 15, ack[0].
//  All three clients req together from reset -> grants in order 0,1,2 in consecutive frames.
//  Client2 re-requests continuously with client0 -> alternation 0,2,0,2; no client starved.
//  Sync falling edge at fc 3 during ISSUE -> fc=7, port held until next fc 15, one ack only.
//  rst_n low during WAIT -> outputs 0 immediately, no ack; fresh req after release serves fine.

Source files
------------

// File: rtl/sdram2_port_arb.sv
// Purpose : shares one sdram2 port among NCLI clients, one access per 16-cycle slot frame, round-robin.
// Latency : grant at fc 14, port sampled at fc 15, ack/read data at fc RD_CNT of the next frame (12..27 clk).
// Backpr. : clients hold cli_req (level) until cli_ack; requests wait for the next fc 14 with the FSM idle.
//
// Ports
//   clk, rst_n      SDRAM clock (shared with sdram2), async active-low reset
//   sync            sdram2 sync; a falling edge realigns the frame counter to 7
//   cli_req/we      per-client request level and write flag
//   cli_be          per-client byte enables, 2 bits each ([1]=upper, [0]=lower)
//   cli_addr/din    per-client word address [20:1] (20 bits) and write data (16 bits)
//   cli_ack         one-cycle completion pulse, one bit per client
//   cli_dout        read longword, shared by all clients, valid with cli_ack
//   busy            an access is granted and not yet acked
//   port_*          sdram2 port x: addr_x0/addr_x1, din_x, wr_x, rd_x, dout_x0

module sdram2_port_arb #(
    parameter int NCLI   = 3,
    parameter int RD_CNT = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sync,
    input  logic [NCLI-1:0]      cli_req,
    input  logic [NCLI-1:0]      cli_we,
    input  logic [2*NCLI-1:0]    cli_be,
    input  logic [20*NCLI-1:0]   cli_addr,
    input  logic [16*NCLI-1:0]   cli_din,
    output logic [NCLI-1:0]      cli_ack,
    output logic [31:0]          cli_dout,
    output logic                 busy,
    output logic [19:0]          port_addr0,
    output logic [19:0]          port_addr1,
    output logic [15:0]          port_din,
    output logic [1:0]           port_wr,
    output logic                 port_rd,
    input  logic [31:0]          port_dout0
);

    localparam int         GW    = (NCLI > 1) ? $clog2(NCLI) : 1;
    localparam logic [3:0] RD_FC = 4'(RD_CNT);
    localparam logic [3:0] GRANT_FC = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    // Per-client views of the flattened request buses.
    logic [19:0] addr_arr [NCLI];
    logic [15:0] din_arr  [NCLI];
    logic [1:0]  be_arr   [NCLI];

    for (genvar i = 0; i < NCLI; i++) begin : g_unpack
        assign addr_arr[i] = cli_addr[20*i +: 20];
        assign din_arr[i]  = cli_din[16*i +: 16];
        assign be_arr[i]   = cli_be[2*i +: 2];
    end

    // Registered state
    state_t          state_q, state_d;
    logic [3:0]      fc_q, fc_d;
    logic            sync_old_q;
    logic [GW-1:0]   g_q, g_d;
    logic [GW-1:0]   rr_q, rr_d;
    logic            op_rd_q, op_rd_d;
    logic [19:0]     addr_q, addr_d;
    logic [15:0]     din_q, din_d;
    logic [1:0]      wr_q, wr_d;
    logic            rd_q, rd_d;
    logic            busy_q, busy_d;
    logic [NCLI-1:0] ack_q, ack_d;
    logic [31:0]     dout_q, dout_d;

    // Client index base+k, wrapped explicitly so non-power-of-2 NCLI never
    // produces an index past the last client.
    function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NCLI) begin
            s = s - NCLI;
        end
        return GW'(s);
    endfunction

    // Round-robin pick: first requester at or after rr.
    logic          pick_vld;
    logic [GW-1:0] pick_idx;

    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 0; k < NCLI; k++) begin
            if (!pick_vld && cli_req[wrap_add(rr_q, k)]) begin
                pick_vld = 1'b1;
                pick_idx = wrap_add(rr_q, k);
            end
        end
    end

    // Frame counter follows sdram2: a falling edge of sync forces slot 7.
    always_comb begin
        fc_d = fc_q + 4'd1;
        if (sync_old_q && !sync) begin
            fc_d = 4'd7;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        rr_d    = rr_q;
        op_rd_d = op_rd_q;
        addr_d  = addr_q;
        din_d   = din_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        busy_d  = busy_q;
        ack_d   = '0;
        dout_d  = dout_q;

        case (state_q)
            ST_IDLE: begin
                if (fc_q == GRANT_FC && pick_vld) begin
                    g_d     = pick_idx;
                    op_rd_d = !cli_we[pick_idx];
                    addr_d  = addr_arr[pick_idx];
                    din_d   = din_arr[pick_idx];
                    // A write with no byte enables degenerates into a refresh slot.
                    wr_d    = be_arr[pick_idx] & {2{cli_we[pick_idx]}};
                    rd_d    = !cli_we[pick_idx];
                    busy_d  = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // fc 0 only follows a real fc 15, so a realignment that skips
                // 15 keeps the command on the port until the next sample.
                if (fc_q == 4'd0) begin
                    wr_d    = 2'b00;
                    rd_d    = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (fc_q == RD_FC) begin
                    if (op_rd_q) begin
                        dout_d = port_dout0;
                    end
                    ack_d[g_q] = 1'b1;
                    busy_d     = 1'b0;
                    rr_d       = wrap_add(g_q, 1);
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fc_q       <= 4'd0;
            sync_old_q <= 1'b0;
            g_q        <= '0;
            rr_q       <= '0;
            op_rd_q    <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            wr_q       <= 2'b00;
            rd_q       <= 1'b0;
            busy_q     <= 1'b0;
            ack_q      <= '0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            fc_q       <= fc_d;
            sync_old_q <= sync;
            g_q        <= g_d;
            rr_q       <= rr_d;
            op_rd_q    <= op_rd_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            dout_q     <= dout_d;
        end
    end

    assign cli_ack    = ack_q;
    assign cli_dout   = dout_q;
    assign busy       = busy_q;
    assign port_addr0 = addr_q;
    assign port_addr1 = addr_q;
    assign port_din   = din_q;
    assign port_wr    = wr_q;
    assign port_rd    = rd_q;

endmodule

// File: tb/tb_sdram2_port_arb.sv
// Purpose : directed self-checking bench for sdram2_port_arb (NCLI=3, RD_CNT=10).
// Latency : bench tracks the frame slot itself from reset release; acks expected at visible fc 11.
// Backpr. : clients hold cli_req until their ack is seen, then drop it on the same cycle.

module tb_sdram2_port_arb;

    localparam int NCLI = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              sync;
    logic [NCLI-1:0]   cli_req;
    logic [NCLI-1:0]   cli_we;
    logic [2*NCLI-1:0] cli_be;
    logic [20*NCLI-1:0] cli_addr;
    logic [16*NCLI-1:0] cli_din;
    logic [NCLI-1:0]   cli_ack;
    logic [31:0]       cli_dout;
    logic              busy;
    logic [19:0]       port_addr0;
    logic [19:0]       port_addr1;
    logic [15:0]       port_din;
    logic [1:0]        port_wr;
    logic              port_rd;
    logic [31:0]       port_dout0;

    int checks   = 0;
    int failures = 0;
    int exp_fc   = 0;

    always #5 clk = ~clk;

    sdram2_port_arb #(.NCLI(NCLI), .RD_CNT(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sync       (sync),
        .cli_req    (cli_req),
        .cli_we     (cli_we),
        .cli_be     (cli_be),
        .cli_addr   (cli_addr),
        .cli_din    (cli_din),
        .cli_ack    (cli_ack),
        .cli_dout   (cli_dout),
        .busy       (busy),
        .port_addr0 (port_addr0),
        .port_addr1 (port_addr1),
        .port_din   (port_din),
        .port_wr    (port_wr),
        .port_rd    (port_rd),
        .port_dout0 (port_dout0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: step to the next falling edge, where outputs are sampled
    // and inputs are driven. exp_fc is the slot value visible in that cycle.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        exp_fc = (exp_fc + 1) % 16;
    endtask

    task automatic wait_fc(input int n);
        int b;
        b = 0;
        while (exp_fc != n && b < 40) begin
            tick();
            b++;
        end
    endtask

    // Ticks until an ack is visible (at least one tick), bounded.
    task automatic wait_ack(output logic [NCLI-1:0] a, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (cli_ack == '0 && n < 60);
        a = cli_ack;
    endtask

    task automatic set_cli(input int c, input logic we, input logic [1:0] be,
                           input logic [19:0] addr, input logic [15:0] din);
        cli_we[c]           = we;
        cli_be[2*c +: 2]    = be;
        cli_addr[20*c +: 20] = addr;
        cli_din[16*c +: 16]  = din;
    endtask

    logic [NCLI-1:0] a;
    int              n;
    int              extra;
    logic            hold_ok;
    logic [NCLI-1:0] alt_exp [4];

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        sync       = 1'b0;
        cli_req    = '0;
        cli_we     = '0;
        cli_be     = '0;
        cli_addr   = '0;
        cli_din    = '0;
        port_dout0 = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_ack",   cli_ack,    0);
        chk("rst_busy",  busy,       0);
        chk("rst_rd",    port_rd,    0);
        chk("rst_wr",    port_wr,    0);
        chk("rst_addr",  port_addr0, 0);
        chk("rst_dout",  cli_dout,   0);

        rst_n  = 1'b1;
        exp_fc = 0;

        // All three clients together from reset: grants 0,1,2 in consecutive frames.
        set_cli(0, 1'b0, 2'b11, 20'h00100, 16'h0);
        set_cli(1, 1'b0, 2'b11, 20'h00200, 16'h0);
        set_cli(2, 1'b0, 2'b11, 20'h00300, 16'h0);
        port_dout0 = 32'h1111_0000;
        cli_req    = 3'b111;
        wait_fc(14);
        tick();
        chk("all_first_addr", port_addr0, 20'h00100);
        chk("all_first_rd",   port_rd,    1);
        for (int k = 0; k < 3; k++) begin
            wait_ack(a, n);
            chk("all_ack",    a,      3'b001 << k);
            chk("all_gap",    n,      (k == 0) ? 12 : 16);
            chk("all_ack_fc", exp_fc, 11);
            cli_req[k] = 1'b0;
        end
        chk("all_dout", cli_dout, 32'h1111_0000);
        chk("all_busy", busy,     0);

        // Clients 0 and 2 held continuously: 0,2,0,2 with rr starting at 0.
        alt_exp[0] = 3'b001;
        alt_exp[1] = 3'b100;
        alt_exp[2] = 3'b001;
        alt_exp[3] = 3'b100;
        cli_req = 3'b101;
        for (int k = 0; k < 4; k++) begin
            wait_ack(a, n);
            chk("alt_ack", a, alt_exp[k]);
            chk("alt_gap", n, 16);
        end
        cli_req = '0;

        // Single read by client 1.
        set_cli(1, 1'b0, 2'b11, 20'h12345, 16'h0);
        port_dout0 = 32'hDEAD_BEEF;
        cli_req    = 3'b010;
        wait_fc(14);
        tick();
        chk("rd_rd15",   port_rd,    1);
        chk("rd_wr15",   port_wr,    0);
        chk("rd_addr0",  port_addr0, 20'h12345);
        chk("rd_addr1",  port_addr1, 20'h12345);
        chk("rd_busy",   busy,       1);
        tick();
        chk("rd_rd0",    port_rd,    1);
        tick();
        chk("rd_clr",    port_rd,    0);
        chk("rd_keep",   port_addr0, 20'h12345);
        wait_ack(a, n);
        chk("rd_ack",    a,          3'b010);
        chk("rd_lat",    n,          10);
        chk("rd_dout",   cli_dout,   32'hDEAD_BEEF);
        chk("rd_busy0",  busy,       0);
        cli_req = '0;
        tick();
        chk("rd_ack_1cy", cli_ack,   0);

        // Write by client 0, lower byte only; read data register must not change.
        set_cli(0, 1'b1, 2'b01, 20'h0ABCD, 16'hA55A);
        port_dout0 = 32'h0BAD_0BAD;
        cli_req    = 3'b001;
        wait_fc(14);
        tick();
        chk("wr_wr",    port_wr,    2'b01);
        chk("wr_rd",    port_rd,    0);
        chk("wr_din",   port_din,   16'hA55A);
        chk("wr_addr",  port_addr0, 20'h0ABCD);
        wait_ack(a, n);
        chk("wr_ack",   a,          3'b001);
        chk("wr_lat",   n,          12);
        chk("wr_dout",  cli_dout,   32'hDEAD_BEEF);
        cli_req = '0;

        // Write with no byte enables: refresh slot, still acked.
        set_cli(0, 1'b1, 2'b00, 20'h00001, 16'h1234);
        cli_req = 3'b001;
        wait_fc(14);
        tick();
        chk("be0_wr",   port_wr, 0);
        chk("be0_rd",   port_rd, 0);
        chk("be0_busy", busy,    1);
        wait_ack(a, n);
        chk("be0_ack",  a,       3'b001);
        cli_req = '0;

        // Sync falling edge at the grant edge: fc jumps 14 -> 7 and skips 15.
        set_cli(1, 1'b0, 2'b11, 20'h0F0F0, 16'h0);
        port_dout0 = 32'hCAFE_F00D;
        cli_req    = 3'b010;
        wait_fc(13);
        sync = 1'b1;
        tick();
        sync = 1'b0;
        tick();
        exp_fc = 7;
        chk("sync_rd",   port_rd,    1);
        chk("sync_addr", port_addr0, 20'h0F0F0);
        hold_ok = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (port_rd !== 1'b1) hold_ok = 1'b0;
        end
        chk("sync_hold", hold_ok, 1);
        tick();
        chk("sync_clr",  port_rd, 0);
        wait_ack(a, n);
        chk("sync_ack",  a,        3'b010);
        chk("sync_lat",  n,        10);
        chk("sync_dout", cli_dout, 32'hCAFE_F00D);
        cli_req = '0;
        extra = 0;
        repeat (24) begin
            tick();
            if (cli_ack != '0) extra++;
        end
        chk("sync_one_ack", extra, 0);

        // Reset while waiting for the ack: everything clears, no ack afterwards.
        set_cli(0, 1'b0, 2'b11, 20'h00555, 16'h0);
        port_dout0 = 32'h5555_AAAA;
        cli_req    = 3'b001;
        wait_fc(14);
        tick();
        chk("rw_busy1", busy, 1);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("rw_busy",  busy,       0);
        chk("rw_addr",  port_addr0, 0);
        chk("rw_dout",  cli_dout,   0);
        chk("rw_rd",    port_rd,    0);
        cli_req = '0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        exp_fc = 0;
        extra  = 0;
        repeat (30) begin
            tick();
            if (cli_ack != '0) extra++;
        end
        chk("rw_no_ack", extra, 0);

        // Fresh read by client 2 after reset release.
        set_cli(2, 1'b0, 2'b11, 20'h0C0C0, 16'h0);
        port_dout0 = 32'h2222_3333;
        cli_req    = 3'b100;
        wait_fc(14);
        tick();
        chk("post_addr", port_addr0, 20'h0C0C0);
        chk("post_rd",   port_rd,    1);
        wait_ack(a, n);
        chk("post_ack",  a,          3'b100);
        chk("post_lat",  n,          12);
        chk("post_dout", cli_dout,   32'h2222_3333);
        cli_req = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
